// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, default target address and helpers.
// Used by both the EEPROM target and the bus master.
package i2c_pkg;

   localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h50;
   localparam int         I2C_SYNC_MIN         = 2;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_DEV_ADDR  = 4'd1,
      ST_DEV_ACK   = 4'd2,
      ST_WORD_ADDR = 4'd3,
      ST_WORD_ACK  = 4'd4,
      ST_WR_DATA   = 4'd5,
      ST_WR_ACK    = 4'd6,
      ST_RD_DATA   = 4'd7,
      ST_RD_ACK    = 4'd8
   } i2c_state_e;

   // Writes stay inside the current 8-byte page: only the low three bits advance.
   function automatic logic [7:0] page_inc(input logic [7:0] ptr);
      return {ptr[7:3], ptr[2:0] + 3'd1};
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one open-drain I2C line plus rise/fall detection.
// Presets to 1 so a reset release on an idle bus never looks like an edge.
module i2c_line_sync
   import i2c_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int N = (STAGES < I2C_SYNC_MIN) ? I2C_SYNC_MIN : STAGES;

   logic [N-1:0] r_sync;
   logic         r_dly;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '1;
         r_dly  <= 1'b1;
      end else begin
         r_sync <= {r_sync[N-2:0], i_line};
         r_dly  <= r_sync[N-1];
      end
   end

   assign o_level = r_sync[N-1];
   assign o_rise  = r_sync[N-1] & ~r_dly;
   assign o_fall  = ~r_sync[N-1] & r_dly;

endmodule

// File: rtl/i2c_slave_eeprom.sv
// AT24C02-style I2C EEPROM target: 256x8 array, page-wrapped writes, sequential reads.
// All bus decisions are made on synchronised SCL/SDA inside the sys_clk domain.
module i2c_slave_eeprom
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] mem_00_data,
   output logic       busy
);

   i2c_state_e r_state;
   i2c_state_e w_state_d;

   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_ptr;
   logic       r_rw;
   logic       r_mack;
   logic       r_sda_oe;
   logic       r_busy;
   logic [7:0] r_mem [256];

   logic       w_scl_lvl, w_scl_rise, w_scl_fall;
   logic       w_sda_lvl, w_sda_rise, w_sda_fall;
   logic       w_start, w_stop;
   logic       w_byte_done;
   logic       w_addr_match;
   logic       w_mem_we;
   logic       w_sda_oe_d;
   logic       w_busy_d;
   logic [7:0] w_rd_byte;

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .i_clk   (sys_clk),
      .i_rst_n (rst_n),
      .i_line  (scl),
      .o_level (w_scl_lvl),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .i_clk   (sys_clk),
      .i_rst_n (rst_n),
      .i_line  (sda),
      .o_level (w_sda_lvl),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   assign w_start      = w_sda_fall & w_scl_lvl;
   assign w_stop       = w_sda_rise & w_scl_lvl;
   assign w_byte_done  = w_scl_fall & (r_bit_cnt == 4'd8);
   assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
   assign w_rd_byte    = r_mem[r_ptr];
   assign w_mem_we     = (r_state == ST_WR_ACK) & w_scl_fall;

   // State register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_d;
   end

   // Next-state logic; STOP and START override every state, mid-byte included.
   always_comb begin
      w_state_d = r_state;
      if (w_stop) begin
         w_state_d = ST_IDLE;
      end else if (w_start) begin
         w_state_d = ST_DEV_ADDR;
      end else if (w_scl_fall) begin
         case (r_state)
            ST_DEV_ADDR:  if (w_byte_done) w_state_d = w_addr_match ? ST_DEV_ACK : ST_IDLE;
            ST_DEV_ACK:   w_state_d = r_rw ? ST_RD_DATA : ST_WORD_ADDR;
            ST_WORD_ADDR: if (w_byte_done) w_state_d = ST_WORD_ACK;
            ST_WORD_ACK:  w_state_d = ST_WR_DATA;
            ST_WR_DATA:   if (w_byte_done) w_state_d = ST_WR_ACK;
            ST_WR_ACK:    w_state_d = ST_WR_DATA;
            ST_RD_DATA:   if (w_byte_done) w_state_d = ST_RD_ACK;
            ST_RD_ACK:    w_state_d = r_mack ? ST_RD_DATA : ST_IDLE;
            default:      w_state_d = ST_IDLE;
         endcase
      end
   end

   // Output logic: SDA drive only moves on an SCL falling edge, registered one cycle later.
   always_comb begin
      w_sda_oe_d = r_sda_oe;
      w_busy_d   = r_busy;
      if (w_stop || w_start) begin
         w_sda_oe_d = 1'b0;
         w_busy_d   = 1'b0;
      end else if (w_scl_fall) begin
         case (r_state)
            ST_DEV_ADDR: begin
               if (w_byte_done) begin
                  w_sda_oe_d = w_addr_match;
                  w_busy_d   = w_addr_match;
               end
            end
            ST_WORD_ADDR, ST_WR_DATA: begin
               if (w_byte_done) w_sda_oe_d = 1'b1;
            end
            ST_DEV_ACK:  w_sda_oe_d = r_rw & ~w_rd_byte[7];
            ST_RD_DATA:  w_sda_oe_d = w_byte_done ? 1'b0 : ~r_shift[6];
            ST_RD_ACK:   w_sda_oe_d = r_mack & ~w_rd_byte[7];
            default:     w_sda_oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sda_oe <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_sda_oe <= w_sda_oe_d;
         r_busy   <= w_busy_d;
      end
   end

   // Shift register, bit counter and word pointer.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'h00;
         r_ptr     <= 8'h00;
         r_rw      <= 1'b0;
         r_mack    <= 1'b0;
      end else if (w_stop || w_start) begin
         r_bit_cnt <= 4'd0;
      end else begin
         case (r_state)
            ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
               if (w_scl_rise) begin
                  r_shift   <= {r_shift[6:0], w_sda_lvl};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end else if (w_byte_done) begin
                  r_bit_cnt <= 4'd0;
                  if (r_state == ST_DEV_ADDR)  r_rw  <= r_shift[0];
                  if (r_state == ST_WORD_ADDR) r_ptr <= r_shift;
               end
            end
            ST_DEV_ACK: begin
               if (w_scl_fall && r_rw) begin
                  r_shift   <= w_rd_byte;
                  r_bit_cnt <= 4'd0;
               end
            end
            ST_WR_ACK: begin
               if (w_scl_fall) r_ptr <= page_inc(r_ptr);
            end
            ST_RD_DATA: begin
               if (w_scl_rise) begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end else if (w_byte_done) begin
                  r_bit_cnt <= 4'd0;
                  r_ptr     <= r_ptr + 8'd1;
               end else if (w_scl_fall) begin
                  r_shift <= {r_shift[6:0], 1'b0};
               end
            end
            ST_RD_ACK: begin
               if (w_scl_rise) begin
                  r_mack <= ~w_sda_lvl;
               end else if (w_scl_fall && r_mack) begin
                  r_shift   <= w_rd_byte;
                  r_bit_cnt <= 4'd0;
               end
            end
            default: begin
               r_bit_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Storage array; writes land with no programming delay.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) r_mem[i] <= 8'h00;
      end else if (w_mem_we) begin
         r_mem[r_ptr] <= r_shift;
      end
   end

   assign sda         = r_sda_oe ? 1'b0 : 1'bz;
   assign busy        = r_busy;
   assign mem_00_data = r_mem[0];

endmodule

// File: tb/tb_i2c_slave_eeprom.sv
// Directed bench for i2c_slave_eeprom: a bit-banged bus master drives byte write,
// random read, page wrap, address mismatch, sequential read wrap and reset mid-read.
module tb_i2c_slave_eeprom;
   import i2c_pkg::*;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   wire        sda;
   logic [7:0] mem_00_data;
   logic       busy;

   int         q_ns   = 2500;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] wr_q[$];

   assign sda = sda_drv ? 1'bz : 1'b0;
   pullup (sda);

   i2c_slave_eeprom #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .scl         (scl_drv),
      .sda         (sda),
      .mem_00_data (mem_00_data),
      .busy        (busy)
   );

   // Clock: 20 time units per period
   always #10 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Bus driver tasks; one SCL period is four quarter waits.
   task automatic qwait();
      #(q_ns);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      sda_drv = 1'b0; qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; qwait();
      scl_drv = 1'b1; qwait();
      sda_drv = 1'b1; qwait();
   endtask

   task automatic write_bit(input logic b);
      sda_drv = b;    qwait();
      scl_drv = 1'b1; qwait(); qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic read_bit(output logic b);
      sda_drv = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      b = sda;        qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic mack);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      write_bit(~mack);
   endtask

   // Write every byte queued in wr_q starting at word address addr.
   task automatic write_seq(input string tag, input logic [7:0] addr);
      logic ack;
      bus_start();
      write_byte(8'hA0, ack); check({tag, "_dev_ack"}, ack, 1);
      write_byte(addr, ack);  check({tag, "_word_ack"}, ack, 1);
      while (wr_q.size() > 0) begin
         write_byte(wr_q.pop_front(), ack);
         check({tag, "_data_ack"}, ack, 1);
      end
      bus_stop();
   endtask

   // Random read of n bytes from addr, checked against exp_q.
   task automatic read_seq(input string tag, input logic [7:0] addr, input int n);
      logic       ack;
      logic [7:0] d;
      bus_start();
      write_byte(8'hA0, ack); check({tag, "_dev_ack"}, ack, 1);
      write_byte(addr, ack);  check({tag, "_word_ack"}, ack, 1);
      bus_start();
      write_byte(8'hA1, ack); check({tag, "_rd_ack"}, ack, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(d, i < n - 1);
         if (exp_q.size() > 0) check({tag, "_rd_data"}, d, exp_q.pop_front());
         else                  check({tag, "_exp_empty"}, 1, 0);
      end
      bus_stop();
   endtask

   initial begin
      logic ack;

      // Reset state
      #45;
      check("rst_sda", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_mem00", mem_00_data, 8'h00);
      check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
      #60 rst_n = 1'b1;
      #200;

      // Byte write at 100 kHz
      q_ns = 2500;
      bus_start();
      write_byte(8'hA0, ack); check("t1_dev_ack", ack, 1);
      check("t1_busy", busy, 1);
      write_byte(8'h00, ack); check("t1_word_ack", ack, 1);
      write_byte(8'hA5, ack); check("t1_data_ack", ack, 1);
      bus_stop();
      qwait();
      check("t1_busy_stop", busy, 0);
      check("t1_mem00", mem_00_data, 8'hA5);

      // Random read, faster bus
      q_ns = 630;
      wr_q = '{8'h3C};
      write_seq("t2_wr", 8'h10);
      exp_q = '{8'h3C};
      read_seq("t2_rd", 8'h10, 1);
      check("t2_mem00", mem_00_data, 8'hA5);

      // Page wrap on write: 06,07 then 00,01; 08 untouched
      wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      write_seq("t3_wr", 8'h06);
      check("t3_mem00", mem_00_data, 8'h33);
      exp_q = '{8'h11, 8'h22, 8'h00};
      read_seq("t3_rd06", 8'h06, 3);
      exp_q = '{8'h33, 8'h44};
      read_seq("t3_rd00", 8'h00, 2);

      // Address mismatch: no ACK, not busy, nothing written
      bus_start();
      write_byte(8'hA2, ack); check("t4_dev_nack", ack, 0);
      check("t4_busy", busy, 0);
      check("t4_state", 32'(dut.r_state), 32'(ST_IDLE));
      write_byte(8'h00, ack); check("t4_word_nack", ack, 0);
      write_byte(8'h77, ack); check("t4_data_nack", ack, 0);
      bus_stop();
      qwait();
      check("t4_mem00", mem_00_data, 8'h33);

      // Write wrap FF->F8, then sequential read wrap FF->00
      wr_q = '{8'hAA, 8'hBB, 8'hCC};
      write_seq("t5_wr", 8'hFE);
      exp_q = '{8'hAA, 8'hBB, 8'h33};
      read_seq("t5_rdfe", 8'hFE, 3);
      exp_q = '{8'hCC};
      read_seq("t5_rdf8", 8'hF8, 1);

      // Reset while the target drives a 0 data bit (mem[00]=0x33, MSB 0)
      bus_start();
      write_byte(8'hA0, ack); check("t6_dev_ack", ack, 1);
      write_byte(8'h00, ack); check("t6_word_ack", ack, 1);
      bus_start();
      write_byte(8'hA1, ack); check("t6_rd_ack", ack, 1);
      check("t6_drive0", sda, 0);
      rst_n = 1'b0;
      #1;
      check("t6_sda_rel", sda, 1);
      check("t6_busy", busy, 0);
      check("t6_state", 32'(dut.r_state), 32'(ST_IDLE));
      check("t6_mem00", mem_00_data, 8'h00);
      scl_drv = 1'b1;
      sda_drv = 1'b1;
      #100 rst_n = 1'b1;
      #400;
      check("t6_no_false_start", 32'(dut.r_state), 32'(ST_IDLE));
      check("t6_busy_after", busy, 0);

      // Final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
